// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   SEL_W        : width of the mux select / channel index
//   arb_state_t  : arbiter FSM state encoding (ST_IDLE, ST_BUSY)
//   rr_pick()    : rotate-priority pick; given a request vector, the last
//                  served index and the channel count, returns the first
//                  requesting index scanning upward from (last+1) mod n.
package mux_rr_arbiter_pkg;

    localparam int SEL_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Offsets are walked from the farthest to the nearest so that the
    // nearest requesting channel is the last assignment and therefore wins.
    // Returns 'last' unchanged when nothing in range is requesting.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [15:0]      req_vec,
        input logic [SEL_W-1:0] last,
        input int               n
    );
        logic [SEL_W-1:0] pick;
        logic [SEL_W-1:0] idx;
        pick = last;
        for (int k = 16; k >= 1; k--) begin
            if (k <= n) begin
                idx = SEL_W'((int'(last) + k) % n);
                if (req_vec[idx]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// WIDTH x CHANNELS data multiplexer.
//   sel    : channel index (registered grant from the arbiter)
//   in_bus : packed channel words, channel i at [i*WIDTH +: WIDTH]
//   data   : selected word (combinational)
// Slots beyond CHANNELS read as zero so any 4-bit select is safe.
module mux_rr_arbiter_mux
    import mux_rr_arbiter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    output logic [WIDTH-1:0]          data
);

    logic [WIDTH-1:0] slice [16];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_slice
            if (gi < CHANNELS) begin : g_live
                assign slice[gi] = in_bus[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign slice[gi] = '0;
            end
        end
    endgenerate

    assign data = slice[sel];

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a WIDTH x CHANNELS data mux.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   req        : per-channel request (slice i of in_bus holds a word)
//   in_bus     : packed channel words
//   req_ack    : one-hot, combinational; word of that channel captured now
//   sel        : registered mux select (= current grant)
//   out_data   : registered captured word, out_chan its channel
//   out_valid  : output word valid; consumed when out_valid && out_ready
//   out_ready  : consumer ready
// A grant lasts at most BURST captured words; every release passes through
// one IDLE cycle, where the next grant is picked starting after 'last'.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int BURST    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    output logic [CHANNELS-1:0]       req_ack,
    output logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam logic [SEL_W-1:0] BURST_LIM = SEL_W'(BURST);
    localparam logic [SEL_W-1:0] LAST_INIT = SEL_W'(CHANNELS - 1);

    arb_state_t       state_reg, state_next;
    logic [SEL_W-1:0] grant_reg, grant_next;
    logic [SEL_W-1:0] last_reg, last_next;
    logic [SEL_W-1:0] burst_cnt_reg, burst_cnt_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic [SEL_W-1:0] out_chan_reg, out_chan_next;
    logic             out_valid_reg, out_valid_next;

    logic [15:0]      req_pad;
    logic [15:0]      ack_full;
    logic             capture;
    logic [WIDTH-1:0] mux_data;

    // Zero-extended so a 4-bit grant can index it for any CHANNELS.
    assign req_pad = 16'(req);

    mux_rr_arbiter_mux #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) u_mux (
        .sel    (grant_reg),
        .in_bus (in_bus),
        .data   (mux_data)
    );

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        last_next      = last_reg;
        burst_cnt_next = burst_cnt_reg;
        out_data_next  = out_data_reg;
        out_chan_next  = out_chan_reg;
        out_valid_next = out_valid_reg;
        capture        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (|req_pad) begin
                    grant_next     = rr_pick(req_pad, last_reg, CHANNELS);
                    burst_cnt_next = '0;
                    state_next     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (req_pad[grant_reg] && (!out_valid_reg || out_ready)) begin
                    capture        = 1'b1;
                    burst_cnt_next = burst_cnt_reg + 4'd1;
                    if (burst_cnt_reg + 4'd1 == BURST_LIM) begin
                        state_next = ST_IDLE;
                        last_next  = grant_reg;
                    end
                end else if (!req_pad[grant_reg]) begin
                    // Requester went away: give up the grant early.
                    state_next = ST_IDLE;
                    last_next  = grant_reg;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Single output stage: a capture overwrites (refills) it, otherwise
        // a consumer accept empties it.
        if (capture) begin
            out_data_next  = mux_data;
            out_chan_next  = grant_reg;
            out_valid_next = 1'b1;
        end else if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    // The reset gate keeps a reset cycle from acknowledging a word that the
    // flush is about to discard.
    assign ack_full = (capture && !reset) ? (16'd1 << grant_reg) : 16'd0;
    assign req_ack  = ack_full[CHANNELS-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= '0;
            last_reg      <= LAST_INIT;
            burst_cnt_reg <= '0;
            out_data_reg  <= '0;
            out_chan_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            last_reg      <= last_next;
            burst_cnt_reg <= burst_cnt_next;
            out_data_reg  <= out_data_next;
            out_chan_reg  <= out_chan_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign sel       = grant_reg;
    assign out_data  = out_data_reg;
    assign out_chan  = out_chan_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer that shares the ALU's WIDTH×CHANNELS data multiplexer among CHANNELS requesters. Each requester raises a request and presents a word on its slice of a packed bus. The arbiter grants one channel at a time for a bounded burst and drives the 4-bit mux select. It registers the selected word into a single output stage with a valid/ready handshake toward the consumer. It sits between the operand sources and the ALU input register.

## Interface
- WIDTH, 8, data word width in bits
- CHANNELS, 4, number of requesters; legal range 2..16, bounded by the 4-bit select
- BURST, 4, maximum words accepted per grant; legal range 1..15
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  CHANNELS  per-channel request; bit i means in_bus slice i holds a valid word
- in_bus  input  CHANNELS*WIDTH  packed data; channel i occupies bits [i*WIDTH +: WIDTH]
- req_ack  output  CHANNELS  one-hot, combinational; bit i high in the cycle channel i's word is captured
- sel  output  4  registered mux select, equal to the current grant
- out_data  output  WIDTH  registered captured word
- out_chan  output  4  channel index of out_data
- out_valid  output  1  out_data/out_chan valid
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready

## Operation
- FSM states: IDLE and BUSY.
- IDLE:
  - If req is nonzero, pick the first set bit scanning upward from (last+1) mod CHANNELS, wrapping.
  - Register the winner into grant/sel, clear burst_cnt, go to BUSY.
  - If req is zero, stay in IDLE.
- BUSY, capture condition: req[grant] && (!out_valid || out_ready).
- On capture:
  - out_data <= in_bus slice[grant], out_chan <= grant, out_valid <= 1.
  - req_ack[grant] = 1.
  - burst_cnt increments.
- Release from BUSY to IDLE, with last <= grant:
  - when req[grant] is low (no capture that cycle), or
  - on the capture that makes burst_cnt equal BURST.
- When out_valid && out_ready and there is no capture, out_valid <= 0.
- Requester contract:
  - Hold the word stable while req is high.
  - Each req_ack consumes exactly one word.
  - Drop req, or present the next word, in the following cycle.
- Arithmetic: burst_cnt and last are 4 bits; rotation wraps modulo CHANNELS, not modulo 16.
- Reset values:
  - state IDLE, grant/sel 0, last CHANNELS-1 (channel 0 has first priority), burst_cnt 0.
  - out_valid 0, out_data 0, out_chan 0, req_ack 0.
- Reset mid-burst discards the grant and any unconsumed output word; no req_ack is asserted in a reset cycle.

## Timing
- Request to first capture:
  - req rises in IDLE at cycle 0; grant is registered at edge 0→1.
  - req_ack is high during cycle 1.
  - out_valid is high from cycle 2.
- Within a burst, one word per cycle while out_ready stays high.
- Backpressure: with out_valid=1 and out_ready=0, there is no capture and req_ack stays 0; the grant holds and burst_cnt is unchanged.
- Rotation costs one IDLE cycle between grants.
- Simultaneous events:
  - Capture and consumer accept in the same cycle: out_valid stays 1 with the new word.
  - req[grant] dropping in the same cycle the output is consumed: release to IDLE, out_valid <= 0.
- Single requester: it is re-granted after its one IDLE cycle; there is no starvation of others because last advances.

## Structure
- Shared package holds:
  - the state encoding constants (ST_IDLE, ST_BUSY);
  - SEL_W = 4;
  - the rotate-priority pick function (request vector, last → index), also reused by other arbiters.
- Sub-module: the existing MUX_WIDTH_CHAN instance performs the data selection, driven by registered sel.
- The arbiter RTL contains only the FSM, counters and the output stage.

## Test plan
- Reset, then req=0000 for 5 cycles → out_valid=0, sel=0, req_ack=0 throughout.
- req=0001, slice0=8'hA5, out_ready=1 → req_ack[0] in cycle 1; out_valid with out_data=A5, out_chan=0 in cycle 2.
- req=1111 held, BURST=4, out_ready=1 → grants in order 0,1,2,3,0, each 4 acks then one IDLE cycle; out_chan follows the same sequence.
- Grant on channel 2, out_ready=0 for 3 cycles after the first capture → req_ack stays 0, out_data stays stable, burst_cnt=1. Raising out_ready resumes captures one per cycle.
- Channel 1 drops req after 2 words, with req[3]=1 → release after 2 acks, next grant is channel 3, last=1.
- reset asserted mid-burst (burst_cnt=2, out_valid=1) → next cycle: out_valid=0, state IDLE, last=CHANNELS-1; the next grant goes to the lowest requesting channel.
